pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and stall controller for the XM23 decode/execute/memory/writeback pipeline. It keeps a 3-entry destination-register scoreboard that mirrors the EX/MEM/WB pipeline-register shift. From that scoreboard it drives the stall vector consumed by the pipeline registers, the operand forwarding selects, and a flush/sleep sequencing FSM. It sits between the decoder and the pipeline registers.

Parameters:
NUM_STAGES, 3, scoreboard depth (EX, MEM, WB); fixed at 3.
REG_W, 3, register-select width.
STALL_W, 8, stall vector width.
FLUSH_CYCLES, 1, number of bubbles inserted after a taken branch (1..7).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
dec_valid  in  1  decoder holds a real instruction this cycle
dec_s  in  REG_W  source register select
dec_s_used  in  1  instruction reads S as a register (RC=0, not a constant)
dec_d  in  REG_W  destination register select (also read as an operand)
dec_d_rd  in  1  instruction reads D
dec_wb  in  1  instruction writes D (WB)
dec_load  in  1  instruction is a memory load
dec_slp  in  1  instruction is SLP
br_taken  in  1  execute stage resolved a taken branch
wake  in  1  wake event from sleep
stall_o  out  STALL_W  stall causes; bit0 load-use, bit1 sleep, bit2 flush, others 0
fwd_s_o  out  2  S operand source: 0 regfile, 1 EX, 2 MEM, 3 WB
fwd_d_o  out  2  D operand source, same encoding
state_o  out  2  0 RUN, 1 FLUSH, 2 SLEEP

Behaviour:
- Reset (asynchronous, active-high): scoreboard entries invalid; FSM enters RUN; flush counter 0; all outputs 0. Reset asserted mid-flush or mid-sleep aborts immediately to RUN.
- Scoreboard: entries EX, MEM and WB, each holding {valid, dst, load}. The scoreboard shifts EX->MEM->WB on every clk regardless of stall, and WB drops out.
- EX entry load rule:
  - loads {dec_valid & dec_wb, dec_d, dec_load} when stall_o is all zero;
  - otherwise loads a bubble (valid=0).
- Match definition: a read operand matches a stage when that stage's entry is valid and its dst equals the operand select, with the operand's used/rd flag set.
- Load-use stall: asserts stall_o[0] combinationally when the EX entry is a load that matches S or D. This costs exactly one bubble; next cycle the load is in MEM and is forwarded.
- Forwarding:
  - priority is EX (non-load) > MEM > WB > regfile;
  - a load in EX never forwards;
  - selects are 0 while any stall bit is set.
- FSM transitions (priority br_taken > SLP > load-use):
  - RUN:
    - br_taken -> FLUSH with counter=FLUSH_CYCLES;
    - otherwise, dec_valid & dec_slp & no stall -> SLEEP. The SLP instruction itself issues that cycle.
  - FLUSH:
    - stall_o[2]=1 each cycle;
    - counter decrements and the FSM returns to RUN when it reaches 1;
    - br_taken while in FLUSH reloads the counter.
  - SLEEP:
    - stall_o[1]=1 until wake is sampled high, then returns to RUN the next cycle;
    - br_taken in SLEEP -> FLUSH (older branch wins);
    - wake while in RUN is ignored.
- Simultaneous load-use and flush: only stall_o[2] asserts.
- Latency: stall_o and forwarding selects are combinational from decode inputs and registered state. The FSM reacts one cycle after the triggering input.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined: forwarding as above; only the load-use case stalls.
- Undefined:
  - fwd_s_o and fwd_d_o are tied to 0;
  - any operand match in EX, MEM or WB asserts stall_o[0]. A RAW dependency on the immediately preceding ALU instruction therefore costs 3 stall cycles.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - STALL_LOAD_USE, STALL_SLEEP and STALL_FLUSH bit indices;
  - fwd_sel_t enum (FWD_REG, FWD_EX, FWD_MEM, FWD_WB);
  - ctrl_state_t enum (RUN, FLUSH, SLEEP);
  - sb_entry_t struct {valid, dst, load}.
- Sub-module hazard_scoreboard holds the entry shift register and the match/forward compare logic. The top level holds the FSM and flush counter.

Test Plan:
- ADD R1,R2 (dec_wb, d=1), then next cycle an instruction reading s=1 -> fwd_s_o=1 (EX), stall_o=0; one cycle later the same read gives fwd_s_o=2.
- LD R3 (dec_load, d=3), then a reader with s=3 -> stall_o=8'h01 for exactly 1 cycle, then fwd_s_o=2, and the EX entry holds a bubble.
- br_taken pulse with FLUSH_CYCLES=2 -> state_o=1 and stall_o=8'h04 for 2 cycles, then RUN; a second br_taken in the first flush cycle extends the flush.
- SLP issued -> next cycle state_o=2 and stall_o=8'h02; wake after 5 cycles -> RUN one cycle later; wake pulsed while in RUN has no effect.
- rst asserted asynchronously mid-SLEEP and mid-FLUSH -> state_o=0, stall_o=0 and all fwd selects 0 immediately; the scoreboard is empty afterwards (no forwarding hit).
- HAZARD_FWD_EN undefined: ADD R1, then a reader of R1 -> stall_o[0] for 3 cycles, fwd_s_o always 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the XM23 hazard/stall controller.
// Stall bit indices, forwarding selects, FSM states, scoreboard entry.
package pipeline_ctrl_pkg;

    localparam int DST_W = 3;

    localparam int STALL_LOAD_USE = 0;
    localparam int STALL_SLEEP    = 1;
    localparam int STALL_FLUSH    = 2;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        SLEEP = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic             valid;
        logic [DST_W-1:0] dst;
        logic             load;
    } sb_entry_t;

    // Youngest producer wins; a load still in EX has no data yet.
    function automatic fwd_sel_t fwd_pick(input logic [2:0] hit,
                                          input logic ex_load);
        fwd_sel_t sel;
        sel = FWD_REG;
        if (hit[0] && !ex_load) begin
            sel = FWD_EX;
        end else if (hit[1]) begin
            sel = FWD_MEM;
        end else if (hit[2]) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decoder/pipeline-register side bundle of the hazard controller.
// master: decoder + execute drive dec_*/br_taken/wake; slave: controller.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W   = 3,
    parameter int STALL_W = 8
);
    logic               dec_valid;
    logic [REG_W-1:0]   dec_s;
    logic               dec_s_used;
    logic [REG_W-1:0]   dec_d;
    logic               dec_d_rd;
    logic               dec_wb;
    logic               dec_load;
    logic               dec_slp;
    logic               br_taken;
    logic               wake;
    logic [STALL_W-1:0] stall_o;
    logic [1:0]         fwd_s_o;
    logic [1:0]         fwd_d_o;
    logic [1:0]         state_o;

    modport master (
        output dec_valid, dec_s, dec_s_used, dec_d, dec_d_rd,
        output dec_wb, dec_load, dec_slp, br_taken, wake,
        input  stall_o, fwd_s_o, fwd_d_o, state_o
    );

    modport slave (
        input  dec_valid, dec_s, dec_s_used, dec_d, dec_d_rd,
        input  dec_wb, dec_load, dec_slp, br_taken, wake,
        output stall_o, fwd_s_o, fwd_d_o, state_o
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB destination shift register + operand compare.
// Ports: clk, rst, issue_en/ex_in (next EX entry), rd_* operands,
// hazard (stall request), fwd_s/fwd_d (forward selects before stall gating).
module hazard_scoreboard
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_W      = 3,
    parameter bit FWD_EN     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_en,
    input  sb_entry_t        ex_in,
    input  logic [REG_W-1:0] rd_s,
    input  logic             rd_s_used,
    input  logic [REG_W-1:0] rd_d,
    input  logic             rd_d_used,
    output logic             hazard,
    output fwd_sel_t         fwd_s,
    output fwd_sel_t         fwd_d
);

    // Index 0 = EX, 1 = MEM, 2 = WB.
    sb_entry_t sb [NUM_STAGES];

    logic [NUM_STAGES-1:0] s_hit;
    logic [NUM_STAGES-1:0] d_hit;
    logic                  load_use;

    // Shifts every cycle, even while stalled; a stall injects a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                sb[k] <= '0;
            end
        end else begin
            sb[0] <= issue_en ? ex_in : '0;
            for (int k = 1; k < NUM_STAGES; k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    always_comb begin
        s_hit = '0;
        d_hit = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            s_hit[k] = rd_s_used && sb[k].valid && (sb[k].dst == rd_s);
            d_hit[k] = rd_d_used && sb[k].valid && (sb[k].dst == rd_d);
        end
    end

    assign load_use = sb[0].load & (s_hit[0] | d_hit[0]);

    // Without forwarding every in-flight producer blocks its readers.
    assign hazard = FWD_EN ? load_use : (|s_hit | |d_hit);
    assign fwd_s  = FWD_EN ? fwd_pick(s_hit, sb[0].load) : FWD_REG;
    assign fwd_d  = FWD_EN ? fwd_pick(d_hit, sb[0].load) : FWD_REG;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// XM23 hazard/stall controller: stall vector, operand forwarding, flush/sleep FSM.
// Ports: clk, rst (async, active-high), hz (slave modport: dec_*, br_taken,
// wake in; stall_o, fwd_s_o, fwd_d_o, state_o out). Macro HAZARD_FWD_EN
// enables forwarding; without it every RAW match stalls and selects stay 0.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_STAGES   = 3,
    parameter int REG_W        = 3,
    parameter int STALL_W      = 8,
    parameter int FLUSH_CYCLES = 1
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave hz
);

`ifdef HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    ctrl_state_t        state;
    logic [2:0]         cnt;
    logic [STALL_W-1:0] stall;
    logic               issue_en;
    logic               hazard;
    fwd_sel_t           fwd_s;
    fwd_sel_t           fwd_d;
    sb_entry_t          ex_in;

    assign ex_in = '{valid: hz.dec_valid & hz.dec_wb,
                     dst:   hz.dec_d,
                     load:  hz.dec_load};

    hazard_scoreboard #(
        .NUM_STAGES (NUM_STAGES),
        .REG_W      (REG_W),
        .FWD_EN     (FWD_EN)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .issue_en  (issue_en),
        .ex_in     (ex_in),
        .rd_s      (hz.dec_s),
        .rd_s_used (hz.dec_s_used),
        .rd_d      (hz.dec_d),
        .rd_d_used (hz.dec_d_rd),
        .hazard    (hazard),
        .fwd_s     (fwd_s),
        .fwd_d     (fwd_d)
    );

    // Flush and sleep mask data hazards: nothing issues in those states.
    always_comb begin
        stall = '0;
        unique case (state)
            FLUSH:   stall[STALL_FLUSH]    = 1'b1;
            SLEEP:   stall[STALL_SLEEP]    = 1'b1;
            default: stall[STALL_LOAD_USE] = hazard;
        endcase
    end

    assign issue_en   = ~|stall;
    assign hz.stall_o = stall;
    assign hz.fwd_s_o = issue_en ? fwd_s : FWD_REG;
    assign hz.fwd_d_o = issue_en ? fwd_d : FWD_REG;
    assign hz.state_o = state;

    // cnt holds the flush cycles still owed, including the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (hz.br_taken) begin
                        state <= FLUSH;
                        cnt   <= FLUSH_LOAD;
                    end else if (hz.dec_valid && hz.dec_slp && issue_en) begin
                        state <= SLEEP;
                    end
                end
                FLUSH: begin
                    if (hz.br_taken) begin
                        cnt <= FLUSH_LOAD;
                    end else if (cnt <= 3'd1) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                SLEEP: begin
                    if (hz.br_taken) begin
                        state <= FLUSH;
                        cnt   <= FLUSH_LOAD;
                    end else if (hz.wake) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed steps then random traffic,
// every cycle checked against an instruction-history reference model.
module tb_pipeline_hazard_ctrl;

    localparam int FC = 2;

    typedef struct {
        bit       v;
        logic [2:0] s;
        bit       su;
        logic [2:0] d;
        bit       drd;
        bit       wb;
        bit       ld;
        bit       slp;
        bit       br;
        bit       wk;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   fwd_en;

    // Issued-instruction history by age: 0 = just issued (in EX).
    int h_v [3];
    int h_d [3];
    int h_l [3];
    int m_state;
    int m_left;

    pipeline_hazard_ctrl_if #(.REG_W(3), .STALL_W(8)) hz ();

    pipeline_hazard_ctrl #(
        .NUM_STAGES   (3),
        .REG_W        (3),
        .STALL_W      (8),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t x;
        x = '{default: 0};
        return x;
    endfunction

    function automatic stim_t alu(int d, int s);
        stim_t x;
        x = idle();
        x.v = 1; x.s = 3'(s); x.su = 1; x.d = 3'(d); x.drd = 1; x.wb = 1;
        return x;
    endfunction

    function automatic stim_t rdr(int s);
        stim_t x;
        x = idle();
        x.v = 1; x.s = 3'(s); x.su = 1;
        return x;
    endfunction

    function automatic stim_t lod(int d);
        stim_t x;
        x = idle();
        x.v = 1; x.d = 3'(d); x.wb = 1; x.ld = 1;
        return x;
    endfunction

    function automatic stim_t slp();
        stim_t x;
        x = idle();
        x.v = 1; x.slp = 1;
        return x;
    endfunction

    function automatic stim_t rnd();
        stim_t x;
        x.v   = $urandom_range(0, 3) != 0;
        x.s   = 3'($urandom_range(0, 3));
        x.su  = $urandom_range(0, 1) != 0;
        x.d   = 3'($urandom_range(0, 3));
        x.drd = $urandom_range(0, 1) != 0;
        x.wb  = $urandom_range(0, 2) != 0;
        x.ld  = $urandom_range(0, 3) == 0;
        x.slp = $urandom_range(0, 15) == 0;
        x.br  = $urandom_range(0, 11) == 0;
        x.wk  = $urandom_range(0, 3) == 0;
        return x;
    endfunction

    function automatic bit reads(int age, logic [2:0] sel, bit used);
        return used && h_v[age] != 0 && h_d[age] == int'(sel);
    endfunction

    function automatic logic [1:0] pick(logic [2:0] sel, bit used,
                                        logic [7:0] es);
        if (!fwd_en || es != 8'h00) return 2'd0;
        for (int a = 0; a < 3; a++) begin
            if (reads(a, sel, used) && !(a == 0 && h_l[0] != 0))
                return 2'(a + 1);
        end
        return 2'd0;
    endfunction

    function automatic void m_eval(input stim_t x, output logic [7:0] es,
                                   output logic [1:0] efs,
                                   output logic [1:0] efd);
        bit haz;
        bit r;
        haz = 0;
        if (m_state == 1) begin
            es = 8'h04;
        end else if (m_state == 2) begin
            es = 8'h02;
        end else begin
            for (int a = 0; a < 3; a++) begin
                r = reads(a, x.s, x.su) || reads(a, x.d, x.drd);
                if (fwd_en) haz = haz | (r && a == 0 && h_l[0] != 0);
                else        haz = haz | r;
            end
            es = haz ? 8'h01 : 8'h00;
        end
        efs = pick(x.s, x.su, es);
        efd = pick(x.d, x.drd, es);
    endfunction

    function automatic void m_step(input stim_t x, input logic [7:0] es);
        for (int a = 2; a > 0; a--) begin
            h_v[a] = h_v[a-1];
            h_d[a] = h_d[a-1];
            h_l[a] = h_l[a-1];
        end
        h_v[0] = (es == 8'h00 && x.v && x.wb) ? 1 : 0;
        h_d[0] = int'(x.d);
        h_l[0] = (es == 8'h00 && x.ld) ? 1 : 0;
        case (m_state)
            0: begin
                if (x.br) begin
                    m_state = 1;
                    m_left  = FC;
                end else if (x.v && x.slp && es == 8'h00) begin
                    m_state = 2;
                end
            end
            1: begin
                m_left = x.br ? FC : m_left - 1;
                if (m_left == 0) m_state = 0;
            end
            default: begin
                if (x.br) begin
                    m_state = 1;
                    m_left  = FC;
                end else if (x.wk) begin
                    m_state = 0;
                end
            end
        endcase
    endfunction

    function automatic void m_reset();
        for (int a = 0; a < 3; a++) begin
            h_v[a] = 0;
            h_d[a] = 0;
            h_l[a] = 0;
        end
        m_state = 0;
        m_left  = 0;
    endfunction

    task automatic drive(input stim_t x);
        hz.dec_valid  = x.v;
        hz.dec_s      = x.s;
        hz.dec_s_used = x.su;
        hz.dec_d      = x.d;
        hz.dec_d_rd   = x.drd;
        hz.dec_wb     = x.wb;
        hz.dec_load   = x.ld;
        hz.dec_slp    = x.slp;
        hz.br_taken   = x.br;
        hz.wake       = x.wk;
    endtask

    task automatic cyc(input stim_t x, input int w_st, input int w_fs,
                       input int w_state, input string tag);
        logic [7:0] es;
        logic [1:0] efs;
        logic [1:0] efd;
        @(negedge clk);
        drive(x);
        #1;
        m_eval(x, es, efs, efd);
        chk({tag, ":stall"}, hz.stall_o, es);
        chk({tag, ":fwd_s"}, {6'd0, hz.fwd_s_o}, {6'd0, efs});
        chk({tag, ":fwd_d"}, {6'd0, hz.fwd_d_o}, {6'd0, efd});
        chk({tag, ":state"}, {6'd0, hz.state_o}, 8'(m_state));
        if (w_st >= 0)
            chk({tag, ":stall_lit"}, hz.stall_o, 8'(w_st));
        if (w_fs >= 0)
            chk({tag, ":fwd_s_lit"}, {6'd0, hz.fwd_s_o}, 8'(w_fs));
        if (w_state >= 0)
            chk({tag, ":state_lit"}, {6'd0, hz.state_o}, 8'(w_state));
        @(posedge clk);
        m_step(x, es);
    endtask

    task automatic rst_mid(input stim_t x, input string tag);
        @(negedge clk);
        drive(x);
        #2;
        rst = 1'b1;
        #1;
        chk({tag, ":state"}, {6'd0, hz.state_o}, 8'h00);
        chk({tag, ":stall"}, hz.stall_o, 8'h00);
        chk({tag, ":fwd_s"}, {6'd0, hz.fwd_s_o}, 8'h00);
        chk({tag, ":fwd_d"}, {6'd0, hz.fwd_d_o}, 8'h00);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        stim_t x;
        int f;
`ifdef HAZARD_FWD_EN
        fwd_en = 1'b1;
`else
        fwd_en = 1'b0;
`endif
        f = fwd_en ? 1 : 0;
        m_reset();
        rst = 1'b1;
        drive(idle());
        #3;
        chk("reset:state", {6'd0, hz.state_o}, 8'h00);
        chk("reset:stall", hz.stall_o, 8'h00);
        chk("reset:fwd_s", {6'd0, hz.fwd_s_o}, 8'h00);
        chk("reset:fwd_d", {6'd0, hz.fwd_d_o}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        cyc(idle(), 0, 0, 0, "idle");

        // ALU producer followed by back-to-back readers
        cyc(alu(1, 2), 0, 0, 0, "add_r1");
        cyc(rdr(1), f != 0 ? 0 : 1, f != 0 ? 1 : 0, 0, "raw1");
        cyc(rdr(1), f != 0 ? 0 : 1, f != 0 ? 2 : 0, 0, "raw2");
        cyc(rdr(1), f != 0 ? 0 : 1, f != 0 ? 3 : 0, 0, "raw3");
        cyc(rdr(1), 0, 0, 0, "raw4");

        // load-use
        cyc(lod(3), 0, 0, 0, "ld_r3");
        cyc(rdr(3), 1, 0, 0, "lu1");
        cyc(rdr(3), f != 0 ? 0 : 1, f != 0 ? 2 : 0, 0, "lu2");
        cyc(rdr(3), f != 0 ? 0 : 1, f != 0 ? 3 : 0, 0, "lu3");
        cyc(idle(), 0, 0, 0, "lu_drain");

        // branch flush and extension
        x = idle(); x.br = 1;
        cyc(x, 0, 0, 0, "br");
        cyc(idle(), 4, 0, 1, "fl1");
        cyc(idle(), 4, 0, 1, "fl2");
        cyc(idle(), 0, 0, 0, "fl_done");
        cyc(x, 0, 0, 0, "br2");
        cyc(x, 4, 0, 1, "flx1");
        cyc(idle(), 4, 0, 1, "flx2");
        cyc(idle(), 4, 0, 1, "flx3");
        cyc(idle(), 0, 0, 0, "flx_done");

        // sleep / wake
        cyc(slp(), 0, 0, 0, "slp");
        for (int i = 0; i < 4; i++) cyc(idle(), 2, 0, 2, "sleep");
        x = idle(); x.wk = 1;
        cyc(x, 2, 0, 2, "wake");
        cyc(idle(), 0, 0, 0, "awake");
        cyc(x, 0, 0, 0, "wake_run");
        cyc(idle(), 0, 0, 0, "still_run");

        // branch while asleep
        cyc(slp(), 0, 0, 0, "slp2");
        x = idle(); x.br = 1;
        cyc(x, 2, 0, 2, "sleep_br");
        cyc(idle(), 4, 0, 1, "sb_fl1");
        cyc(idle(), 4, 0, 1, "sb_fl2");
        cyc(idle(), 0, 0, 0, "sb_done");

        // load-use hidden by flush
        x = lod(3); x.br = 1;
        cyc(x, 0, 0, 0, "ld_br");
        cyc(rdr(3), 4, 0, 1, "lu_fl1");
        cyc(rdr(3), 4, 0, 1, "lu_fl2");
        cyc(idle(), 0, 0, 0, "lu_fl_done");

        // stalled SLP does not sleep
        cyc(lod(3), 0, 0, 0, "ld_slp");
        x = slp(); x.s = 3'd3; x.su = 1;
        cyc(x, 1, 0, 0, "slp_stalled");
        cyc(idle(), 0, 0, 0, "no_sleep");

        // async reset mid-sleep
        cyc(slp(), 0, 0, 0, "slp3");
        cyc(idle(), 2, 0, 2, "sleep3");
        rst_mid(idle(), "rst_sleep");
        cyc(idle(), 0, 0, 0, "post_rst_s");

        // async reset mid-flush drops in-flight producer
        x = alu(5, 2); x.br = 1;
        cyc(x, 0, 0, 0, "add_br");
        rst_mid(rdr(5), "rst_flush");
        cyc(rdr(5), 0, 0, 0, "sb_empty");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) rst_mid(rnd(), "rst_rnd");
            else cyc(rnd(), -1, -1, -1, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
